// File: rtl/mmio_pkg.sv
// Shared types and defaults for the memory-mapped peripheral bus initiator
// and the peripherals that answer it.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] PERIPH_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] PERIPH_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] ERR_RDATA_DEF   = 32'h0000_0000;

  // GPIO register select, decoded from Address[0]
  localparam logic GPIO_OUT_OFS = 1'b0;
  localparam logic GPIO_IN_OFS  = 1'b1;

  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/mmio_timeout_cnt.sv
// 8-bit saturating wait counter with synchronous clear; tc flags count == TERMINAL.
// Registered count, combinational tc; no backpressure.
module mmio_timeout_cnt #(
  parameter int unsigned TERMINAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(TERMINAL));

endmodule

// File: rtl/mmio_bus_initiator.sv
// One-at-a-time CPU load/store initiator: zero-wait hit completes 2 cycles after req, miss after 1.
// Requests are only sampled in IDLE; cpu_req while busy is dropped, the core must hold or re-issue.
module mmio_bus_initiator
  import mmio_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
  parameter logic [31:0] PERIPH_MASK = PERIPH_MASK_DEF,
  parameter int unsigned TIMEOUT     = 8,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        busy,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic        Select,
  output logic        WrEn,
  input  logic [31:0] DataOut,
  input  logic        Ready
);

  state_t state;
  logic   hit;
  logic   tmo_tc;

  assign hit = win_hit(cpu_addr, PERIPH_BASE, PERIPH_MASK);

  // Counter holds the number of WAIT cycles already spent without Ready
  mmio_timeout_cnt #(
    .TERMINAL(TIMEOUT - 1)
  ) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(state == STROBE),
    .en ((state == WAIT) && !Ready),
    .tc (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cpu_rdata <= 32'd0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      busy      <= 1'b0;
      Address   <= 32'd0;
      DataIn    <= 32'd0;
      Select    <= 1'b0;
      WrEn      <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      Select   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            busy <= 1'b1;
            if (hit) begin
              Address <= cpu_addr;
              WrEn    <= cpu_we;
              if (cpu_we) DataIn <= cpu_wdata;
              Select  <= 1'b1;
              state   <= STROBE;
            end else begin
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
              if (!cpu_we) cpu_rdata <= ERR_RDATA;
              state    <= DONE;
            end
          end
        end
        STROBE, WAIT: begin
          // Ready takes priority over the final timeout cycle
          if (Ready) begin
            cpu_done <= 1'b1;
            if (!WrEn) cpu_rdata <= DataOut;
            state    <= DONE;
          end else if (state == STROBE) begin
            state <= WAIT;
          end else if (tmo_tc) begin
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            if (!WrEn) cpu_rdata <= ERR_RDATA;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Directed bench for mmio_bus_initiator: inputs change and outputs are sampled 1ns after each rising edge.
module tb_mmio_bus_initiator;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_err, busy;
  logic [31:0] Address, DataIn, DataOut;
  logic        Select, WrEn, Ready;

  int checks   = 0;
  int failures = 0;
  int done_cnt;

  localparam logic [31:0] A_OUT = {PERIPH_BASE_DEF[31:1], GPIO_OUT_OFS};
  localparam logic [31:0] A_IN  = {PERIPH_BASE_DEF[31:1], GPIO_IN_OFS};

  mmio_bus_initiator dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .busy(busy),
    .Address(Address), .DataIn(DataIn), .Select(Select), .WrEn(WrEn),
    .DataOut(DataOut), .Ready(Ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    DataOut = 32'd0; Ready = 1'b0;

    // Reset state
    #12;
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", Address, 32'd0);
    chk("rst_datain", DataIn, 32'd0);
    chk("rst_select", {31'd0, Select}, 32'd0);
    chk("rst_wren", {31'd0, WrEn}, 32'd0);
    tick();
    rst = 1'b1;

    // Ready in IDLE is ignored
    Ready = 1'b1;
    tick();
    chk("idle_ready_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready_done", {31'd0, cpu_done}, 32'd0);
    Ready = 1'b0;

    // Store 0xA5, Ready in the STROBE cycle
    issue(1'b1, A_OUT, 32'h0000_00A5);
    tick();
    cpu_req = 1'b0;
    chk("st_select", {31'd0, Select}, 32'd1);
    chk("st_wren", {31'd0, WrEn}, 32'd1);
    chk("st_datain", DataIn, 32'h0000_00A5);
    chk("st_addr", Address, A_OUT);
    chk("st_busy", {31'd0, busy}, 32'd1);
    chk("st_done_early", {31'd0, cpu_done}, 32'd0);
    Ready = 1'b1; DataOut = 32'hDEAD_BEEF;
    tick();
    Ready = 1'b0;
    chk("st_done", {31'd0, cpu_done}, 32'd1);
    chk("st_err", {31'd0, cpu_err}, 32'd0);
    chk("st_select_off", {31'd0, Select}, 32'd0);
    chk("st_rdata_kept", cpu_rdata, 32'd0);
    tick();
    chk("st_done_pulse", {31'd0, cpu_done}, 32'd0);
    chk("st_idle", {31'd0, busy}, 32'd0);

    // Load with 3 WAIT cycles
    issue(1'b0, A_IN, 32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    chk("ld_select", {31'd0, Select}, 32'd1);
    chk("ld_wren", {31'd0, WrEn}, 32'd0);
    chk("ld_busy1", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_wait_busy", {31'd0, busy}, 32'd1);
      chk("ld_wait_select", {31'd0, Select}, 32'd0);
      chk("ld_wait_done", {31'd0, cpu_done}, 32'd0);
    end
    Ready = 1'b1; DataOut = 32'h0000_003C;
    tick();
    Ready = 1'b0; DataOut = 32'hFFFF_FFFF;
    chk("ld_done", {31'd0, cpu_done}, 32'd1);
    chk("ld_err", {31'd0, cpu_err}, 32'd0);
    chk("ld_rdata", cpu_rdata, 32'h0000_003C);
    chk("ld_busy5", {31'd0, busy}, 32'd1);
    chk("ld_datain_kept", DataIn, 32'h0000_00A5);
    tick();
    chk("ld_idle", {31'd0, busy}, 32'd0);
    chk("ld_rdata_held", cpu_rdata, 32'h0000_003C);

    // Out-of-window store keeps rdata, out-of-window load returns ERR_RDATA
    issue(1'b1, 32'h3000_0000, 32'h5555_5555);
    tick();
    cpu_req = 1'b0;
    chk("mst_done", {31'd0, cpu_done}, 32'd1);
    chk("mst_err", {31'd0, cpu_err}, 32'd1);
    chk("mst_rdata", cpu_rdata, 32'h0000_003C);
    chk("mst_select", {31'd0, Select}, 32'd0);
    chk("mst_datain", DataIn, 32'h0000_00A5);
    tick();
    issue(1'b0, 32'h2000_0000, 32'd0);
    tick();
    cpu_req = 1'b0;
    chk("mld_done", {31'd0, cpu_done}, 32'd1);
    chk("mld_err", {31'd0, cpu_err}, 32'd1);
    chk("mld_rdata", cpu_rdata, ERR_RDATA_DEF);
    chk("mld_select", {31'd0, Select}, 32'd0);
    chk("mld_addr", Address, A_IN);
    tick();
    chk("mld_err_clr", {31'd0, cpu_err}, 32'd0);

    // Ready on the 8th (final) WAIT cycle wins over the timeout
    issue(1'b0, A_OUT, 32'd0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rl_wait_done", {31'd0, cpu_done}, 32'd0);
    end
    Ready = 1'b1; DataOut = 32'h5A5A_0001;
    tick();
    Ready = 1'b0;
    chk("rl_done", {31'd0, cpu_done}, 32'd1);
    chk("rl_err", {31'd0, cpu_err}, 32'd0);
    chk("rl_rdata", cpu_rdata, 32'h5A5A_0001);
    tick();

    // No Ready: abort after 8 WAIT cycles
    issue(1'b0, A_IN, 32'd0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_wait_done", {31'd0, cpu_done}, 32'd0);
      chk("to_wait_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("to_done", {31'd0, cpu_done}, 32'd1);
    chk("to_err", {31'd0, cpu_err}, 32'd1);
    chk("to_rdata", cpu_rdata, ERR_RDATA_DEF);
    tick();
    chk("to_idle", {31'd0, busy}, 32'd0);

    // Second req pulse during WAIT is ignored
    done_cnt = 0;
    issue(1'b0, A_IN, 32'd0);
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    Ready = 1'b1; DataOut = 32'h0000_0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      Ready = 1'b0;
      if (cpu_done) done_cnt++;
    end
    chk("dup_done_count", done_cnt, 32'd1);
    chk("dup_rdata", cpu_rdata, 32'h0000_0011);
    chk("dup_idle", {31'd0, busy}, 32'd0);

    // Held req is re-accepted in the IDLE cycle after DONE
    issue(1'b1, A_OUT, 32'h0000_0077);
    Ready = 1'b1;
    tick();
    chk("hold_sel1", {31'd0, Select}, 32'd1);
    tick();
    chk("hold_done1", {31'd0, cpu_done}, 32'd1);
    tick();
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_idle_sel", {31'd0, Select}, 32'd0);
    tick();
    cpu_req = 1'b0;
    chk("hold_sel2", {31'd0, Select}, 32'd1);
    chk("hold_busy2", {31'd0, busy}, 32'd1);
    tick();
    Ready = 1'b0;
    chk("hold_done2", {31'd0, cpu_done}, 32'd1);
    chk("hold_rdata", cpu_rdata, 32'h0000_0011);
    tick();

    // Asynchronous reset while Select is high
    issue(1'b1, A_IN, 32'h0000_0099);
    tick();
    cpu_req = 1'b0;
    chk("ar_select_pre", {31'd0, Select}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("ar_select", {31'd0, Select}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_addr", Address, 32'd0);
    chk("ar_datain", DataIn, 32'd0);
    chk("ar_wren", {31'd0, WrEn}, 32'd0);
    chk("ar_rdata", cpu_rdata, 32'd0);
    chk("ar_done", {31'd0, cpu_done}, 32'd0);
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_done) done_cnt++;
    end
    chk("ar_no_done", done_cnt, 32'd0);
    chk("ar_idle", {31'd0, busy}, 32'd0);
    issue(1'b1, A_OUT, 32'h0000_0042);
    Ready = 1'b1;
    tick();
    cpu_req = 1'b0;
    chk("ar_st_select", {31'd0, Select}, 32'd1);
    chk("ar_st_datain", DataIn, 32'h0000_0042);
    tick();
    Ready = 1'b0;
    chk("ar_st_done", {31'd0, cpu_done}, 32'd1);
    chk("ar_st_err", {31'd0, cpu_err}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
